// File: rtl/helix_pkg.sv
// Shared Helix types and constants used by the context arbiter and related schedulers.
package helix_pkg;

    localparam int unsigned HELIX_CONTEXT_W = 32;

    typedef enum logic [1:0] {
        PM_LOAD  = 2'b00,
        PM_SHIFT = 2'b01,
        PM_XOR   = 2'b10,
        PM_ADD   = 2'b11
    } helix_pmode_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } helix_arb_state_t;

endpackage

// File: rtl/helix_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module helix_rr_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // Explicit wrap so N need not be a power of two.
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx[ID_W-1:0]]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/helix_ctx_arbiter.sv
// Round-robin arbiter sharing one helix_reactor context port; a grant is held for a whole
// burst so beats from different sources never interleave in the reactor accumulator.
module helix_ctx_arbiter
    import helix_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned CONTEXT_W = HELIX_CONTEXT_W,
    parameter int unsigned MAX_BEATS = 16,
    localparam int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*CONTEXT_W-1:0] req_data,
    input  logic [N_REQ*2-1:0]     req_mode,
    input  logic [N_REQ-1:0]       req_last,
    output logic                   ctx_valid,
    input  logic                   ctx_ready,
    output logic [CONTEXT_W-1:0]   ctx_data,
    output logic [1:0]             precision_mode,
    output logic [ID_W-1:0]        tag_id,
    output logic                   tag_last,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    helix_arb_state_t state_q, state_d;
    helix_pmode_t     mode_q, mode_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  tag_id_q, tag_id_d;
    logic             tag_last_q, tag_last_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             accept;
    logic             burst_end;

    logic [CONTEXT_W-1:0] data_arr [N_REQ];
    logic [1:0]           mode_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*CONTEXT_W +: CONTEXT_W];
        assign mode_arr[g] = req_mode[g*2 +: 2];
    end

    helix_rr_picker #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        mode_d     = mode_q;
        tag_id_d   = tag_id_q;
        tag_last_d = tag_last_q;
        req_ready  = '0;
        ctx_valid  = 1'b0;
        ctx_data   = '0;
        accept     = 1'b0;
        burst_end  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d    = winner;
                    mode_d     = helix_pmode_t'(mode_arr[winner]);
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                ctx_valid          = req_valid[grant_q];
                ctx_data           = data_arr[grant_q];
                req_ready[grant_q] = ctx_ready;
                accept             = ctx_valid & ctx_ready;
                // A burst ends on the source's last flag or when the beat limit forces release.
                burst_end          = req_last[grant_q] | (beat_cnt_q == LAST_CNT);
                if (accept) begin
                    tag_id_d   = grant_q;
                    tag_last_d = burst_end;
                    if (burst_end) begin
                        rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
                        state_d  = ARB_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            mode_q     <= PM_LOAD;
            tag_id_q   <= '0;
            tag_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            mode_q     <= mode_d;
            tag_id_q   <= tag_id_d;
            tag_last_q <= tag_last_d;
        end
    end

    assign precision_mode = mode_q;
    assign tag_id         = tag_id_q;
    assign tag_last       = tag_last_q;
    assign busy           = (state_q == ARB_BURST);

endmodule

// File: tb/tb_helix_ctx_arbiter.sv
// Directed bench for helix_ctx_arbiter: reset, single burst, round-robin, forced release,
// backpressure and reset mid-burst.
module tb_helix_ctx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N*2-1:0] req_mode;
    logic [N-1:0]   req_last;
    logic           ctx_valid;
    logic           ctx_ready;
    logic [W-1:0]   ctx_data;
    logic [1:0]     precision_mode;
    logic [1:0]     tag_id;
    logic           tag_last;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] acc_q[$];

    always #5 clk = ~clk;

    helix_ctx_arbiter #(
        .N_REQ     (N),
        .CONTEXT_W (W),
        .MAX_BEATS (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_mode       (req_mode),
        .req_last       (req_last),
        .ctx_valid      (ctx_valid),
        .ctx_ready      (ctx_ready),
        .ctx_data       (ctx_data),
        .precision_mode (precision_mode),
        .tag_id         (tag_id),
        .tag_last       (tag_last),
        .busy           (busy)
    );

    // Record every beat the reactor side accepts.
    always @(posedge clk) begin
        if (rst_n && ctx_valid && ctx_ready) acc_q.push_back(ctx_data);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        req_last  = '0;
        rst_n     = 1'b0;
        cyc();
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_last  = '0;
        req_data  = '0;
        req_mode  = '1;
        ctx_ready = 1'b1;
        cyc();
        cyc();
        checks++; if (ctx_valid !== 1'b0) begin errors++; $display("FAIL reset_ctx_valid got %0b want 0", ctx_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (tag_id !== 2'd0) begin errors++; $display("FAIL reset_tag_id got %0d want 0", tag_id); end
        checks++; if (tag_last !== 1'b0) begin errors++; $display("FAIL reset_tag_last got %0b want 0", tag_last); end
        checks++; if (precision_mode !== 2'b00) begin errors++; $display("FAIL reset_pmode got %b want 00", precision_mode); end
        checks++; if (ctx_data !== 16'h0) begin errors++; $display("FAIL reset_ctx_data got %h want 0", ctx_data); end
        req_valid = '0;
        req_mode  = '0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single();
        logic [W-1:0] beats [3];
        beats[0] = 16'hA0A0; beats[1] = 16'hB1B1; beats[2] = 16'hC2C2;
        req_valid      = 4'b0001;
        req_data[0+:W] = beats[0];
        req_mode[1:0]  = 2'b11;
        req_last       = '0;
        ctx_ready      = 1'b1;
        #1;
        checks++; if (ctx_valid !== 1'b0) begin errors++; $display("FAIL single_bubble got %0b want 0", ctx_valid); end
        cyc();
        for (int b = 0; b < 3; b++) begin
            req_data[0+:W] = beats[b];
            req_last[0]    = (b == 2);
            #1;
            checks++; if (ctx_valid !== 1'b1) begin errors++; $display("FAIL single_valid b%0d got %0b want 1", b, ctx_valid); end
            checks++; if (ctx_data !== beats[b]) begin errors++; $display("FAIL single_data b%0d got %h want %h", b, ctx_data, beats[b]); end
            checks++; if (precision_mode !== 2'b11) begin errors++; $display("FAIL single_pmode b%0d got %b want 11", b, precision_mode); end
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready b%0d got %b want 0001", b, req_ready); end
            cyc();
            checks++; if (tag_id !== 2'd0 || tag_last !== (b == 2)) begin
                errors++; $display("FAIL single_tag b%0d got (%0d,%0b) want (0,%0b)", b, tag_id, tag_last, b == 2);
            end
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %0b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int g;
        apply_reset();
        for (int i = 0; i < 4; i++) req_data[i*W +: W] = 16'h1000 + 16'(i);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        ctx_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            exp_rdy = 4'b0001 << g;
            #1;
            checks++; if (busy !== 1'b0 || ctx_valid !== 1'b0) begin
                errors++; $display("FAIL rr_idle n%0d got busy=%0b valid=%0b want 0,0", n, busy, ctx_valid);
            end
            cyc();
            checks++; if (req_ready !== exp_rdy || ctx_data !== 16'h1000 + 16'(g)) begin
                errors++; $display("FAIL rr_grant n%0d got rdy=%b data=%h want rdy=%b data=%h",
                                   n, req_ready, ctx_data, exp_rdy, 16'h1000 + 16'(g));
            end
            cyc();
            checks++; if (tag_id !== 2'(g) || tag_last !== 1'b1) begin
                errors++; $display("FAIL rr_tag n%0d got (%0d,%0b) want (%0d,1)", n, tag_id, tag_last, g);
            end
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_forced_release();
        int beat = 0;
        int grp_len [3];
        grp_len[0] = 4; grp_len[1] = 4; grp_len[2] = 2;
        apply_reset();
        req_valid      = 4'b0110;
        req_last       = '0;
        ctx_ready      = 1'b1;
        req_data[2*W +: W] = 16'h2200;
        for (int grp = 0; grp < 3; grp++) begin
            #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL forced_bubble g%0d got %0b want 0", grp, busy); end
            cyc();
            for (int k = 0; k < grp_len[grp]; k++) begin
                req_data[1*W +: W] = 16'h2100 + 16'(beat);
                req_last[1] = (grp == 2) && (k == 1);
                #1;
                checks++; if (req_ready !== 4'b0010 || ctx_data !== 16'h2100 + 16'(beat)) begin
                    errors++; $display("FAIL forced_beat%0d got rdy=%b data=%h want rdy=0010 data=%h",
                                       beat, req_ready, ctx_data, 16'h2100 + 16'(beat));
                end
                cyc();
                checks++; if (tag_id !== 2'd1 || tag_last !== (k == grp_len[grp] - 1)) begin
                    errors++; $display("FAIL forced_tag%0d got (%0d,%0b) want (1,%0b)",
                                       beat, tag_id, tag_last, k == grp_len[grp] - 1);
                end
                beat++;
            end
            if (grp == 0) begin
                // req2 has waited through req1's forced-released burst.
                req_last[2] = 1'b1;
                #1;
                checks++; if (busy !== 1'b0 || ctx_valid !== 1'b0) begin
                    errors++; $display("FAIL forced_idle2 got busy=%0b valid=%0b want 0,0", busy, ctx_valid);
                end
                cyc();
                checks++; if (req_ready !== 4'b0100 || ctx_data !== 16'h2200) begin
                    errors++; $display("FAIL forced_req2 got rdy=%b data=%h want 0100 2200", req_ready, ctx_data);
                end
                cyc();
                checks++; if (tag_id !== 2'd2 || tag_last !== 1'b1) begin
                    errors++; $display("FAIL forced_tag_req2 got (%0d,%0b) want (2,1)", tag_id, tag_last);
                end
                req_valid   = 4'b0010;
                req_last[2] = 1'b0;
            end
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d [3];
        logic pat [5];
        int idx = 0;
        d[0] = 16'hD000; d[1] = 16'hD111; d[2] = 16'hD222;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
        apply_reset();
        acc_q.delete();
        req_valid      = 4'b0001;
        req_mode[1:0]  = 2'b01;
        req_data[0+:W] = d[0];
        req_last       = '0;
        ctx_ready      = 1'b0;
        #1;
        cyc();
        for (int c = 0; c < 5; c++) begin
            req_data[0+:W] = d[idx];
            req_last[0]    = (idx == 2);
            ctx_ready      = pat[c];
            #1;
            checks++; if (ctx_valid !== 1'b1 || ctx_data !== d[idx]) begin
                errors++; $display("FAIL bp_data c%0d got v=%0b data=%h want 1 %h", c, ctx_valid, ctx_data, d[idx]);
            end
            checks++; if (precision_mode !== 2'b01) begin errors++; $display("FAIL bp_pmode c%0d got %b want 01", c, precision_mode); end
            checks++; if (req_ready !== (pat[c] ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL bp_ready c%0d got %b want %b", c, req_ready, pat[c] ? 4'b0001 : 4'b0000);
            end
            cyc();
            if (pat[c]) idx++;
            checks++; if (tag_id !== 2'd0 || tag_last !== (idx == 3)) begin
                errors++; $display("FAIL bp_tag c%0d got (%0d,%0b) want (0,%0b)", c, tag_id, tag_last, idx == 3);
            end
            req_mode[1:0] = 2'b10;
        end
        req_valid = '0;
        req_last  = '0;
        ctx_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after got %0b want 0", busy); end
        checks++; if (acc_q.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d want 3", acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (acc_q[i] !== d[i]) begin errors++; $display("FAIL bp_seq%0d got %h want %h", i, acc_q[i], d[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req_valid          = 4'b0100;
        req_last           = 4'b0100;
        req_data[2*W +: W] = 16'h3200;
        ctx_ready          = 1'b1;
        #1;
        cyc();
        cyc();
        checks++; if (tag_id !== 2'd2 || tag_last !== 1'b1) begin
            errors++; $display("FAIL rm_pre_tag got (%0d,%0b) want (2,1)", tag_id, tag_last);
        end
        req_valid     = 4'b1000;
        req_last      = '0;
        req_mode[7:6] = 2'b10;
        #1;
        cyc();
        for (int b = 0; b < 2; b++) begin
            req_data[3*W +: W] = 16'h3300 + 16'(b);
            #1;
            checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_ready b%0d got %b want 1000", b, req_ready); end
            cyc();
            checks++; if (tag_id !== 2'd3 || tag_last !== 1'b0) begin
                errors++; $display("FAIL rm_tag b%0d got (%0d,%0b) want (3,0)", b, tag_id, tag_last);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ctx_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL rm_async got busy=%0b valid=%0b rdy=%b want 0 0 0000", busy, ctx_valid, req_ready);
        end
        checks++; if (tag_id !== 2'd0 || tag_last !== 1'b0 || precision_mode !== 2'b00) begin
            errors++; $display("FAIL rm_regs got tag=(%0d,%0b) pm=%b want (0,0) 00", tag_id, tag_last, precision_mode);
        end
        #1;
        rst_n              = 1'b1;
        req_valid          = 4'b1010;
        req_last           = 4'b0010;
        req_data[1*W +: W] = 16'h3100;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle got %0b want 0", busy); end
        cyc();
        checks++; if (req_ready !== 4'b0010 || ctx_data !== 16'h3100) begin
            errors++; $display("FAIL rm_regrant got rdy=%b data=%h want 0010 3100", req_ready, ctx_data);
        end
        cyc();
        checks++; if (tag_id !== 2'd1 || tag_last !== 1'b1) begin
            errors++; $display("FAIL rm_tag_after got (%0d,%0b) want (1,1)", tag_id, tag_last);
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_forced_release();
        test_backpressure();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
